// File: rtl/mbist_session_pkg.sv
// mbist_session_pkg: shared state encoding and status codes for the MBIST self-repair session
// Contents: state_t (IDLE..DONE), STAT_* 2-bit status codes reported on status.
package mbist_session_pkg;
    typedef enum logic [2:0] {IDLE, CLEAR, RUN1, EVAL1, RUN2, EVAL2, DONE} state_t;
    localparam logic [1:0] STAT_PASS         = 2'b00;
    localparam logic [1:0] STAT_REPAIRED     = 2'b01;
    localparam logic [1:0] STAT_UNREPAIRABLE = 2'b10;
    localparam logic [1:0] STAT_TIMEOUT      = 2'b11;
endpackage

// File: rtl/mbist_fail_tracker.sv
// mbist_fail_tracker: MAX_REPAIRS-entry table of distinct failing addresses
// Ports: clk, rst (sync, active-low), clear (empties table), enable (accept strobes),
//        valid/addr (fail strobe), count (distinct fails stored, saturating), overflow (sticky).
module mbist_fail_tracker #(
    parameter int ADDR_WIDTH  = 5,
    parameter int MAX_REPAIRS = 2,
    parameter int CNT_WIDTH   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  enable,
    input  logic                  valid,
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic [CNT_WIDTH-1:0]  count,
    output logic                  overflow
);
    logic [ADDR_WIDTH-1:0]  tab [MAX_REPAIRS];
    logic [MAX_REPAIRS-1:0] used, sel;
    logic hit, store;
    // entries fill from bit 0 upward; sel is the lowest free slot, one-hot
    assign sel   = ~used & (used + 1'b1);
    assign store = enable && valid && !hit;
    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < MAX_REPAIRS; i++)
            hit = hit || (used[i] && tab[i] == addr);
    end
    always_ff @(posedge clk) begin
        if (!rst || clear) begin
            used     <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (store) begin
            if (&used) overflow <= 1'b1;
            else begin
                used  <= used | sel;
                count <= count == '1 ? count : count + 1'b1;
            end
        end
    end
    always_ff @(posedge clk) begin
        for (int i = 0; i < MAX_REPAIRS; i++)
            if (store && sel[i]) tab[i] <= addr;
    end
endmodule

// File: rtl/mbist_session_ctrl.sv
// mbist_session_ctrl: sequences one MBIST/MBISR self-repair session with per-pass watchdog
// Ports: clk, rst (sync, active-low); start -> busy/done/status/fail_count;
//        bist_start/bist_abort out, bist_done/bist_fail_valid/bist_fail_addr in;
//        rep_clear/rep_lock to the MBISR controller. All outputs registered.
// Build option: define MBIST_RETEST_EN to add the locked verification pass (RUN2/EVAL2).
module mbist_session_ctrl #(
    parameter int ADDR_WIDTH     = 5,
    parameter int MAX_REPAIRS    = 2,
    parameter int CNT_WIDTH      = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [1:0]            status,
    output logic [CNT_WIDTH-1:0]  fail_count,
    output logic                  bist_start,
    output logic                  bist_abort,
    input  logic                  bist_done,
    input  logic                  bist_fail_valid,
    input  logic [ADDR_WIDTH-1:0] bist_fail_addr,
    output logic                  rep_clear,
    output logic                  rep_lock
);
    import mbist_session_pkg::*;
    localparam int WDW = $clog2(TIMEOUT_CYCLES);
    // wd holds k in the k-th run cycle; deciding at TIMEOUT-2 puts the registered
    // abort exactly TIMEOUT-1 cycles after the bist_start cycle
    localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT_CYCLES - 2);
    state_t state, state_n;
    logic [WDW-1:0] wd;
    logic [1:0] status_n;
    logic busy_n, done_n, bist_start_n, rep_clear_n, rep_lock_n;
    logic overflow, running, expire, trk_clear;
`ifdef MBIST_RETEST_EN
    logic retest_fail;
`endif
    assign running   = state == RUN1 || state == RUN2;
    assign expire    = running && !bist_done && wd == WD_LAST;
    assign trk_clear = state_n == CLEAR;
    mbist_fail_tracker #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .MAX_REPAIRS(MAX_REPAIRS),
        .CNT_WIDTH  (CNT_WIDTH)
    ) u_tracker (
        .clk     (clk),
        .rst     (rst),
        .clear   (trk_clear),
        .enable  (state == RUN1),
        .valid   (bist_fail_valid),
        .addr    (bist_fail_addr),
        .count   (fail_count),
        .overflow(overflow)
    );
    always_comb begin
        state_n  = state;
        status_n = status;
        case (state)
            IDLE, DONE: if (start) begin
                state_n  = CLEAR;
                status_n = STAT_PASS;
            end
            CLEAR: state_n = RUN1;
            RUN1:  state_n = bist_done ? EVAL1 : expire ? DONE : RUN1;
            EVAL1: begin
`ifdef MBIST_RETEST_EN
                state_n = (fail_count != '0 && !overflow) ? RUN2 : DONE;
`else
                state_n = DONE;
`endif
                status_n = fail_count == '0 ? STAT_PASS : overflow ? STAT_UNREPAIRABLE : STAT_REPAIRED;
            end
`ifdef MBIST_RETEST_EN
            RUN2:  state_n = bist_done ? EVAL2 : expire ? DONE : RUN2;
            EVAL2: begin
                state_n  = DONE;
                status_n = retest_fail ? STAT_UNREPAIRABLE : STAT_REPAIRED;
            end
`endif
            default: state_n = IDLE;
        endcase
        if (expire) status_n = STAT_TIMEOUT;
    end
    assign busy_n       = state_n inside {CLEAR, RUN1, EVAL1, RUN2, EVAL2};
    assign done_n       = state_n == DONE;
    assign rep_clear_n  = state_n == CLEAR;
    assign bist_start_n = (state_n == RUN1 && state != RUN1) || (state_n == RUN2 && state != RUN2);
`ifdef MBIST_RETEST_EN
    assign rep_lock_n   = state_n == RUN2 || state_n == EVAL2;
`else
    assign rep_lock_n   = 1'b0;
`endif
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            status     <= STAT_PASS;
            bist_start <= 1'b0;
            bist_abort <= 1'b0;
            rep_clear  <= 1'b0;
            rep_lock   <= 1'b0;
            wd         <= '0;
        end else begin
            state      <= state_n;
            busy       <= busy_n;
            done       <= done_n;
            status     <= status_n;
            bist_start <= bist_start_n;
            bist_abort <= expire;
            rep_clear  <= rep_clear_n;
            rep_lock   <= rep_lock_n;
            wd         <= (running && state_n == state) ? wd + 1'b1 : '0;
        end
    end
`ifdef MBIST_RETEST_EN
    always_ff @(posedge clk) begin
        if (!rst || state_n == CLEAR) retest_fail <= 1'b0;
        else if (state == RUN2 && bist_fail_valid) retest_fail <= 1'b1;
    end
`endif
endmodule

// File: tb/tb_mbist_session_ctrl.sv
// tb_mbist_session_ctrl: directed self-checking bench for mbist_session_ctrl
module tb_mbist_session_ctrl;
    import mbist_session_pkg::*;
    logic       clk = 1'b0, rst = 1'b0, start = 1'b0, bist_done = 1'b0, bist_fail_valid = 1'b0;
    logic [4:0] bist_fail_addr = '0;
    logic       busy, done, bist_start, bist_abort, rep_clear, rep_lock;
    logic [1:0] status;
    logic [3:0] fail_count;
    int checks = 0, errors = 0, n_bs = 0, n_ab = 0, n_lock = 0, k;

    always #5 clk = ~clk;

    mbist_session_ctrl #(
        .ADDR_WIDTH(5), .MAX_REPAIRS(2), .CNT_WIDTH(4), .TIMEOUT_CYCLES(1024)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .status(status),
        .fail_count(fail_count), .bist_start(bist_start), .bist_abort(bist_abort),
        .bist_done(bist_done), .bist_fail_valid(bist_fail_valid), .bist_fail_addr(bist_fail_addr),
        .rep_clear(rep_clear), .rep_lock(rep_lock)
    );

    always @(negedge clk) begin
        if (bist_start) n_bs++;
        if (bist_abort) n_ab++;
        if (rep_lock) n_lock++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic go();
        n_bs = 0; n_ab = 0; n_lock = 0;
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic strobe(input logic [4:0] a, input int n);
        bist_fail_valid = 1'b1;
        bist_fail_addr  = a;
        step(n);
        bist_fail_valid = 1'b0;
    endtask

    task automatic finish_pass();
        bist_done = 1'b1;
        step(1);
        bist_done = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        step(2);
        chk("rst_outs", {busy, done, status, fail_count, bist_start, bist_abort, rep_clear, rep_lock}, 0);
        rst = 1'b1;
        step(1);
        chk("idle_outs", {busy, done, bist_start, rep_clear}, 0);

        // minimum PASS session: start@0, rep_clear@1, bist_start@2, bist_done@3, done@5
        go();
        chk("min_clear", {rep_clear, busy, done, bist_start}, 4'b1100);
        step(1);
        chk("min_bstart", {bist_start, rep_clear}, 2'b10);
        finish_pass();
        chk("min_eval", {busy, done}, 2'b10);
        step(1);
        chk("min_done", {busy, done, status}, {2'b01, STAT_PASS});

        // no faults, bist_done 400 cycles after bist_start
        go();
        chk("nf_done_drop", done, 0);
        step(1);
        step(400);
        finish_pass();
        k = 0;
        while (!done && k < 20) begin
            step(1);
            k++;
        end
        chk("nf_latency", k, 1);
        chk("nf_status", {done, status, fail_count}, {1'b1, STAT_PASS, 4'd0});
        chk("nf_bstarts", n_bs, 1);

        // fail strobes and bist_done while in DONE are ignored
        strobe(5'h09, 3);
        finish_pass();
        chk("ign_done", {done, busy, fail_count}, {2'b10, 4'd0});
        chk("ign_bstarts", n_bs, 1);

        // one fault reported 5 times
        go();
        step(1);
        strobe(5'h05, 5);
        chk("one_cnt", fail_count, 1);
        finish_pass();
`ifdef MBIST_RETEST_EN
        step(1);
        chk("one_run2", {bist_start, rep_lock, busy}, 3'b111);
        step(2);
        finish_pass();
        chk("one_eval2_lock", rep_lock, 1);
        step(1);
        chk("one_final", {done, rep_lock, status, fail_count}, {2'b10, STAT_REPAIRED, 4'd1});
        chk("one_lock_cycles", n_lock, 4);
        chk("one_bstarts", n_bs, 2);
`else
        step(1);
        chk("one_final", {done, rep_lock, status, fail_count}, {2'b10, STAT_REPAIRED, 4'd1});
        chk("one_lock_cycles", n_lock, 0);
        chk("one_bstarts", n_bs, 1);
`endif

        // overflow: third distinct address arrives with bist_done
        go();
        chk("ovf_cnt_clear", fail_count, 0);
        step(1);
        strobe(5'h03, 1);
        strobe(5'h07, 1);
        strobe(5'h03, 1);
        chk("ovf_cnt2", fail_count, 2);
        bist_fail_addr  = 5'h0C;
        bist_fail_valid = 1'b1;
        finish_pass();
        bist_fail_valid = 1'b0;
        step(1);
        chk("ovf_final", {done, status, fail_count}, {1'b1, STAT_UNREPAIRABLE, 4'd2});
        chk("ovf_bstarts", n_bs, 1);
        chk("ovf_lock", n_lock, 0);

        // retest failure: same address again in the locked pass
        go();
        step(1);
        strobe(5'h05, 1);
        finish_pass();
`ifdef MBIST_RETEST_EN
        step(1);
        strobe(5'h05, 1);
        finish_pass();
        step(1);
        chk("rtf_final", {done, status, fail_count}, {1'b1, STAT_UNREPAIRABLE, 4'd1});
`else
        step(1);
        chk("rtf_final", {done, status, fail_count}, {1'b1, STAT_REPAIRED, 4'd1});
`endif

        // watchdog expiry with bist_done withheld
        go();
        step(1);
        k = 0;
        while (!bist_abort && k < 1100) begin
            step(1);
            k++;
        end
        chk("to_latency", k, 1023);
        chk("to_status", {done, busy, status}, {2'b10, STAT_TIMEOUT});
        step(1);
        chk("to_pulse", {bist_abort, n_ab[3:0]}, {1'b0, 4'd1});

        // bist_done in the expiry cycle wins
        go();
        step(1);
        step(1022);
        finish_pass();
        step(1);
        chk("race_status", {done, status}, {1'b1, STAT_PASS});
        chk("race_abort", n_ab, 0);

        // start in RUN1 ignored, then reset mid-RUN1
        go();
        step(1);
        start = 1'b1;
        step(1);
        start = 1'b0;
        chk("ign_start", {busy, rep_clear, bist_start}, 3'b100);
        step(1);
        chk("ign_start_bs", n_bs, 1);
        rst = 1'b0;
        step(1);
        chk("mid_rst_outs", {busy, done, status, fail_count, bist_start, bist_abort, rep_clear, rep_lock}, 0);
        chk("mid_rst_state", dut.state, IDLE);
        rst = 1'b1;
        finish_pass();
        chk("post_rst_idle", {busy, done, bist_start}, 0);
        chk("post_rst_abort", n_ab, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mbist_session_ctrl.md
# mbist_session_ctrl

Session sequencer that runs the MBIST/MBISR datapath as one self-repair session: clear repair map, first March pass with fail collection, repair decision, optional locked verification pass, final status. Sits between the chip-level start/done pins and the MBIST controller plus MBISR controller. Replaces direct wiring of `start`/`done`/`fail`. Tracks distinct failing addresses against repair capacity and guards each pass with a watchdog.

## Interface
- `ADDR_WIDTH`, 5: fail address width.
- `MAX_REPAIRS`, 2: spare entries available in MBISR.
- `CNT_WIDTH`, 4: width of the distinct-fail counter; saturates at all-ones.
- `TIMEOUT_CYCLES`, 1024: watchdog limit per pass, in cycles; ≥2.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-low reset.
- `start`  in  1  session request; sampled only in IDLE or DONE.
- `busy`  out  1  high in CLEAR/RUN1/EVAL1/RUN2/EVAL2.
- `done`  out  1  level; high in DONE until the next accepted `start`.
- `status`  out  2  00 PASS, 01 REPAIRED, 10 UNREPAIRABLE, 11 TIMEOUT; valid while `done`.
- `fail_count`  out  CNT_WIDTH  distinct failing addresses seen in RUN1.
- `bist_start`  out  1  one-cycle pulse to the MBIST controller.
- `bist_abort`  out  1  one-cycle pulse on watchdog expiry.
- `bist_done`  in  1  pass-complete pulse.
- `bist_fail_valid`  in  1  per-read fail strobe.
- `bist_fail_addr`  in  ADDR_WIDTH  address qualified by `bist_fail_valid`.
- `rep_clear`  out  1  one-cycle pulse that clears the MBISR repair map.
- `rep_lock`  out  1  level; freezes the MBISR map (no new allocations) during RUN2.

## Operation
- Reset (`rst`=0 at a clock edge): state IDLE. All outputs 0: `busy`, `done`, `status`=00, `fail_count`=0, all pulses 0, `rep_lock`=0. Fail table and watchdog are cleared. Reset mid-session aborts immediately. No `bist_abort` is issued on reset.
- IDLE/DONE → CLEAR on `start`=1. Entering CLEAR clears the fail table, `fail_count`, and `status`, and drops `done`.
- CLEAR (1 cycle): `rep_clear`=1. Next state RUN1.
- RUN1:
  - `bist_start`=1 in the first cycle only; watchdog is reset to 0 and counts every cycle.
  - Each `bist_fail_valid` compares `bist_fail_addr` to the stored table entries.
  - If the address matches an entry, nothing happens.
  - If it is new and the table is not full, it is stored and `fail_count` increments (saturating).
  - If it is new and the table is full, the sticky `overflow` flag is set.
  - `bist_done` → EVAL1.
- EVAL1 (1 cycle):
  - `fail_count`=0 → DONE, PASS.
  - `overflow` → DONE, UNREPAIRABLE.
  - Otherwise → RUN2 if retest is compiled in, else DONE, REPAIRED.
- RUN2:
  - `rep_lock`=1 throughout; `bist_start` pulses in the first cycle; watchdog restarts.
  - Any `bist_fail_valid` sets the sticky `retest_fail` flag. The table is not updated.
  - `bist_done` → EVAL2.
- EVAL2 (1 cycle): `retest_fail` → UNREPAIRABLE, else REPAIRED; next state DONE. `rep_lock` stays high through EVAL2 and drops on entry to DONE.
- Watchdog: in RUN1/RUN2, when the count reaches `TIMEOUT_CYCLES`-1 without `bist_done`, the block pulses `bist_abort`, goes to DONE, and sets status TIMEOUT.
- Boundaries:
  - `bist_done` and expiry in the same cycle: `bist_done` wins.
  - `bist_fail_valid` in the same cycle as `bist_done` is still counted.
  - `bist_fail_valid` and `bist_done` outside RUN1/RUN2 are ignored.
  - `start` while `busy` is ignored.
  - `fail_count` saturates at 2^CNT_WIDTH−1 and never wraps.

## Timing
- `start` at cycle 0 gives `rep_clear` at cycle 1 and `bist_start` at cycle 2.
- `bist_done` at cycle T gives EVAL at T+1, then either DONE/`done`=1 at T+2 or the RUN2 `bist_start` at T+2.
- All outputs are registered. No combinational input-to-output paths.
- The minimum session with a PASS result is 5 cycles from `start` to `done`, given `bist_done` the cycle after `bist_start`.

## Configuration
- `MBIST_RETEST_EN` defined: RUN2/EVAL2 exist, and REPAIRED is reported only after a clean locked pass.
- `MBIST_RETEST_EN` undefined:
  - RUN2/EVAL2 are not built, and `rep_lock` is tied to 0.
  - EVAL1 with 0 < `fail_count` and no overflow reports REPAIRED directly.

## Structure
- Package `mbist_session_pkg` holds:
  - the state encoding (IDLE, CLEAR, RUN1, EVAL1, RUN2, EVAL2, DONE);
  - the status codes (STAT_PASS, STAT_REPAIRED, STAT_UNREPAIRABLE, STAT_TIMEOUT).
- Sub-module `mbist_fail_tracker` holds the MAX_REPAIRS-entry distinct-address table and owns the table logic from RUN1:
  - inputs: clear, enable, valid, addr;
  - outputs: count, overflow.
- The FSM and watchdog live in the top module.

## Test plan
- No faults: `start`; `bist_done` 400 cycles after `bist_start`; no fail strobes → `status`=00, `fail_count`=0, a single `bist_start`, `done`=1.
- One fault: 0x05 reported 5 times in RUN1, clean RUN2 → `fail_count`=1, `rep_lock` high only in RUN2/EVAL2, `status`=01 (retest on).
- Overflow: 0x03, 0x07, 0x0C with MAX_REPAIRS=2 → `fail_count`=2, `status`=10, a single `bist_start`, RUN2 skipped.
- Retest failure: 0x05 in RUN1, 0x05 again in RUN2 → `status`=10, `fail_count`=1.
- Timeout: `bist_done` withheld → `bist_abort` pulse 1023 cycles after the `bist_start` cycle, `status`=11, `done`=1.
- Reset/ignore: `start` pulsed in RUN1 has no effect; `rst`=0 mid-RUN1 → the next cycle has every output at 0 and the state is IDLE.
